pipe_skid32: RTL and testbench

//  Downstream end of a 32-bit pipeline register. A plain D flip-flop stage
//   has no way to push back on the stage before it; this block adds that.
//  It is a two-entry skid buffer between two CPU pipeline stages, with

---
 rtl/pipe_skid32.sv | 88 ++++++++
 tb/tb_pipe_skid32.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid32.sv
// Two-entry skid buffer closing a 32-bit pipeline stage: valid/ready on both sides,
// synchronous flush, and a wrapping count of words delivered downstream.
module pipe_skid32 #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             flush,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state, state_nx;
  logic [W-1:0]     main_q, main_nx;
  logic [W-1:0]     skid_q, skid_nx;
  logic [CNT_W-1:0] cnt_q;
  logic             in_xfer, out_xfer;

  // Both handshake outputs decode the state register only, so neither side
  // sees a combinational path from the other.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign xfer_cnt  = cnt_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nx;
      main_q <= main_nx;
      skid_q <= skid_nx;
      // Downstream already took the word, so a flush cycle still counts it.
      if (out_xfer) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    if (flush) begin
      // Data registers are left alone so out_data keeps its last value.
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_nx = ONE;
            main_nx  = in_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_nx = in_data;
          end else if (in_xfer) begin
            state_nx = TWO;
            skid_nx  = in_data;
          end else if (out_xfer) begin
            state_nx = EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_nx = ONE;
            main_nx  = skid_q;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid32.sv
// Bench for pipe_skid32: directed scenario tasks plus a negedge monitor that
// scoreboards every accepted word against every delivered word.
module tb_pipe_skid32;

  logic        clk = 1'b0;
  logic        clrn;
  logic        flush;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] xfer_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sbq[$];
  logic [15:0] exp_cnt = '0;
  logic        have_hold = 1'b0;
  logic [31:0] hold_data = '0;

  pipe_skid32 #(.W(32), .CNT_W(16)) dut (
    .clk(clk), .clrn(clrn), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: inputs change just after posedge, so the negedge sees a settled cycle.
  always @(negedge clk) begin
    if (!clrn) begin
      sbq.delete();
      exp_cnt   = '0;
      have_hold = 1'b0;
    end else begin
      n_cmp++;
      if (xfer_cnt !== exp_cnt) begin
        n_bad++;
        $display("FAIL mon_cnt: got %h want %h at %0t", xfer_cnt, exp_cnt, $time);
      end
      if (have_hold) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== hold_data) begin
          n_bad++;
          $display("FAIL mon_stable: got v=%b d=%h want v=1 d=%h at %0t",
                   out_valid, out_data, hold_data, $time);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL mon_extra: got %h want no word at %0t", out_data, $time);
        end else begin
          logic [31:0] e;
          e = sbq.pop_front();
          if (out_data !== e) begin
            n_bad++;
            $display("FAIL mon_order: got %h want %h at %0t", out_data, e, $time);
          end
        end
        exp_cnt = exp_cnt + 16'd1;
      end
      if (flush) sbq.delete();
      else if (in_valid && in_ready) sbq.push_back(in_data);
      have_hold = out_valid && !out_ready && !flush;
      hold_data = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    step();
    step();
    clrn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    clrn = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    step();
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || xfer_cnt !== 16'h0) begin
      n_bad++;
      $display("FAIL reset: got v=%b r=%b d=%h c=%h want 0 1 0 0",
               out_valid, in_ready, out_data, xfer_cnt);
    end
    // Load words, then drop reset asynchronously mid-cycle.
    clrn = 1'b1; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
    step();
    in_data = 32'h66;
    step();
    #2 clrn = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || xfer_cnt !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_async: got v=%b r=%b d=%h c=%h want 0 1 0 0",
               out_valid, in_ready, out_data, xfer_cnt);
    end
    idle_inputs();
    do_reset();
  endtask

  task automatic test_stream();
    logic [31:0] w[3];
    w[0] = 32'h1; w[1] = 32'h2; w[2] = 32'h3;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = w[i];
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== w[i]) begin
        n_bad++;
        $display("FAIL stream_%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, w[i]);
      end
    end
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || xfer_cnt !== 16'd3) begin
      n_bad++;
      $display("FAIL stream_end: got v=%b c=%0d want v=0 c=3", out_valid, xfer_cnt);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0 || out_data !== 32'hA) begin
      n_bad++;
      $display("FAIL stall_full: got r=%b d=%h want r=0 d=a", in_ready, out_data);
    end
    step();
    step();
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_drain: got v=%b d=%h r=%b want 1 b 1", out_valid, out_data, in_ready);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || xfer_cnt !== 16'd5) begin
      n_bad++;
      $display("FAIL stall_end: got v=%b c=%0d want v=0 c=5", out_valid, xfer_cnt);
    end
  endtask

  task automatic test_flush();
    logic [15:0] c0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    flush = 1'b1; in_data = 32'hC;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'hA) begin
      n_bad++;
      $display("FAIL flush_two: got v=%b r=%b d=%h want 0 1 a", out_valid, in_ready, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL flush_ghost_%0d: got v=%b d=%h want v=0", i, out_valid, out_data);
      end
    end
    // ONE state: word taken by downstream in the flush cycle counts; new input is dropped.
    c0 = exp_cnt;
    in_valid = 1'b1; in_data = 32'hD;
    step();
    flush = 1'b1; in_data = 32'hE;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || xfer_cnt !== c0 + 16'd1) begin
      n_bad++;
      $display("FAIL flush_one: got v=%b c=%h want v=0 c=%h", out_valid, xfer_cnt, c0 + 16'd1);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_drop: got v=%b d=%h want v=0", out_valid, out_data);
    end
  endtask

  task automatic test_wrap();
    idle_inputs();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_data = i;
      step();
    end
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (xfer_cnt !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL wrap_pre: got %h want ffff", xfer_cnt);
    end
    in_valid = 1'b1; in_data = 32'h1234_5678;
    step();
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (xfer_cnt !== 16'h0000) begin
      n_bad++;
      $display("FAIL wrap: got %h want 0000", xfer_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(99) < 70);
      out_ready = ($urandom_range(99) < 60);
      flush     = ($urandom_range(99) < 3);
      in_data   = $urandom;
      step();
    end
    idle_inputs();
    out_ready = 1'b1;
    step();
    step();
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || sbq.size() != 0) begin
      n_bad++;
      $display("FAIL random_drain: got v=%b pending=%0d want v=0 pending=0", out_valid, sbq.size());
    end
  endtask

  initial begin
    idle_inputs();
    clrn = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
